add_2p_sched: RTL and testbench
===============================

# add_2p_sched

Round-robin scheduler that shares one pipelined 22-bit adder (add_2p, fixed latency LAT) among four requesters. Each cycle it grants at most one pending request and drives the winner's operands into the adder. It carries a requester-ID tag down a shadow pipeline matched to the adder latency. It returns each sum with its ID on a registered result port, and sits between the requesting datapaths and the shared adder instance.

## Interface
- WIDTH, 22, operand/sum bit width (must match the adder)
- LAT, 4, clock edges from adder input change to valid adder sum (add_2p = 4)
- CNTW, 16, width of issued-operation counter
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  1 = new grants allowed; 0 = no new grants, in-flight ops complete
- req  in  4  req[i] = requester i has valid operands, held until granted
- x_in  in  4*WIDTH  operand x, requester i on bits [i*WIDTH +: WIDTH]
- y_in  in  4*WIDTH  operand y, same packing
- gnt  out  4  one-hot grant pulse, registered, high one cycle per issued op
- add_x  out  WIDTH  registered operand x to shared adder
- add_y  out  WIDTH  registered operand y to shared adder
- add_sum  in  WIDTH  sum from shared adder
- res_valid  out  1  result valid, one-cycle pulse per op
- res_id  out  2  requester index of current result
- res_sum  out  WIDTH  registered result
- idle  out  1  1 = no op granted or in flight
- ops_cnt  out  CNTW  number of ops issued since reset, wraps modulo 2^CNTW

## Operation
- Arbitration at every rising edge with reset=0 and en=1. Eligible set: req[i]=1 and gnt[i]=0.
  - A requester granted at the previous edge is masked for one edge. It must drop req, or present new operands, while its gnt is high.
- Round-robin pointer ptr (2 bits, reset 0). The winner is the first eligible index in ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On a grant, ptr <= winner+1 mod 4. With no grant, ptr holds.
- On a grant at edge k:
  - gnt <= onehot(winner).
  - add_x/add_y <= the winner's x_in/y_in slices.
  - tag stage t[0] <= {1, winner}.
  - ops_cnt increments.
- With no grant, gnt <= 0, t[0] valid <= 0, and add_x/add_y hold their previous values.
- Tag pipeline t[0..LAT] of {valid, id}, shifting every edge. There is no stall: the adder has no enable, so no back-pressure exists.
- Result stage: each edge, res_valid <= t[LAT].valid, res_id <= t[LAT].id, res_sum <= add_sum.
  - res_sum is updated every edge, even when res_valid=0.
- The scheduler performs no arithmetic. Sum wrap-around (carry out of bit WIDTH-1) is dropped by the adder and passed through unchanged.
- idle = 1 when gnt == 0 and all t[0..LAT] valid bits are 0.
  - idle is combinational from registers.
- Reset (synchronous) clears:
  - gnt=0, add_x=0, add_y=0, ptr=0, all tag valid/id=0.
  - res_valid=0, res_id=0, res_sum=0, ops_cnt=0, so idle=1 after the reset edge.
- Reset mid-operation: all in-flight tags are discarded. Adder outputs still emerging from the adder pipeline are never flagged valid.
- en falling mid-burst: no grant at any edge with en=0. Already-issued ops still produce res_valid on schedule.

## Timing
- Request sampled at edge k: gnt high and add_x/add_y valid during cycle k..k+1.
- The adder sum is valid after edge k+LAT.
- The result is captured at edge k+LAT+1, so res_valid is high LAT+1 cycles after the gnt pulse (5 cycles for LAT=4).
- Throughput: one op per cycle aggregate, one op per two cycles per requester.
- Results return in issue order. Back-to-back grants give back-to-back res_valid pulses.
- All four requests simultaneous from reset: grants 0,1,2,3 on consecutive edges, then 0 again if still requesting.

## Test plan
- Bench connects add_x/add_y/add_sum to add_2p (LAT=4).
- Single request: req=0001, x0=5, y0=7 -> gnt=0001 for one cycle, then 5 cycles later res_valid=1, res_id=0, res_sum=12, ops_cnt=1, idle=1 afterwards.
- Contention: req=1111 held continuously with distinct operands per requester (requester i: x=i, y=100*i) -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; results in the same order with correct sums.
- Fairness: after a grant to requester 2, with req=1001 pending -> requester 3 is granted before requester 0.
- Wrap: x=0x3FFFFF, y=0x000001 -> res_sum=0x000000. x=0x200000, y=0x200000 -> res_sum=0.
- en=0 while req=1111 -> no gnt pulses; in-flight ops still complete; idle=1 once drained. en=1 again resumes at the current ptr.
- Reset asserted 2 cycles after three grants -> no res_valid ever appears for those ops. After reset, all outputs are 0, idle=1, and the next grant goes to the lowest-index requester (ptr=0).

Source files
------------

// File: rtl/add_2p_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : add_2p_sched_if
// Brief   : Requester / shared-adder / result bundle for the adder scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface add_2p_sched_if #(
  parameter int WIDTH = 22,
  parameter int CNTW  = 16
);
  logic               en;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] x_in;
  logic [4*WIDTH-1:0] y_in;
  logic [3:0]         gnt;
  logic [WIDTH-1:0]   add_x;
  logic [WIDTH-1:0]   add_y;
  logic [WIDTH-1:0]   add_sum;
  logic               res_valid;
  logic [1:0]         res_id;
  logic [WIDTH-1:0]   res_sum;
  logic               idle;
  logic [CNTW-1:0]    ops_cnt;

  // Environment side: requesters plus the shared adder's sum output.
  modport master (
    output en, req, x_in, y_in, add_sum,
    input  gnt, add_x, add_y, res_valid, res_id, res_sum, idle, ops_cnt
  );

  // Scheduler side.
  modport slave (
    input  en, req, x_in, y_in, add_sum,
    output gnt, add_x, add_y, res_valid, res_id, res_sum, idle, ops_cnt
  );
endinterface
`default_nettype wire

// File: rtl/add_2p_sched.sv
`default_nettype none
// ============================================================================
// Module  : add_2p_sched
// Brief   : Round-robin scheduler sharing one LAT-stage pipelined adder among
//           four requesters, with a requester-ID shadow pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module add_2p_sched #(
  parameter int WIDTH = 22,
  parameter int LAT   = 4,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  add_2p_sched_if.slave     bus
);

  logic [3:0]       gnt_q;
  logic [3:0]       gnt_d;
  logic [1:0]       ptr_q;
  logic [WIDTH-1:0] add_x_q;
  logic [WIDTH-1:0] add_y_q;
  logic [LAT:0]     tv_q;
  logic [1:0]       tid_q [LAT+1];
  logic             res_valid_q;
  logic [1:0]       res_id_q;
  logic [WIDTH-1:0] res_sum_q;
  logic [CNTW-1:0]  ops_cnt_q;

  logic [3:0]       elig;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       scan_idx;
  logic             grant;

  // A requester granted last edge still shows stale operands, so mask it.
  always_comb begin
    elig      = bus.req & ~gnt_q;
    win_found = 1'b0;
    win_idx   = 2'd0;
    scan_idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!win_found && elig[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    grant = bus.en & win_found;
    gnt_d = grant ? (4'b0001 << win_idx) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q       <= '0;
      ptr_q       <= '0;
      add_x_q     <= '0;
      add_y_q     <= '0;
      tv_q        <= '0;
      for (int s = 0; s <= LAT; s++) tid_q[s] <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sum_q   <= '0;
      ops_cnt_q   <= '0;
    end else begin
      gnt_q <= gnt_d;
      if (grant) begin
        ptr_q     <= win_idx + 2'd1;
        add_x_q   <= bus.x_in[win_idx*WIDTH +: WIDTH];
        add_y_q   <= bus.y_in[win_idx*WIDTH +: WIDTH];
        ops_cnt_q <= ops_cnt_q + CNTW'(1);
      end
      // Tag shadow pipeline tracks the adder exactly; the adder never stalls.
      tv_q[0]  <= grant;
      tid_q[0] <= win_idx;
      for (int s = 1; s <= LAT; s++) begin
        tv_q[s]  <= tv_q[s-1];
        tid_q[s] <= tid_q[s-1];
      end
      res_valid_q <= tv_q[LAT];
      res_id_q    <= tid_q[LAT];
      res_sum_q   <= bus.add_sum;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.add_x     = add_x_q;
  assign bus.add_y     = add_y_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.ops_cnt   = ops_cnt_q;
  assign bus.idle      = (gnt_q == 4'b0000) && (tv_q == '0);

  a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt_q));

endmodule
`default_nettype wire

// File: tb/tb_add_2p_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_add_2p_sched
// Brief   : Directed, table-driven self-checking bench for add_2p_sched.
// Revision: 1.0 - initial release
// ============================================================================
module tb_add_2p_sched;
  localparam int WIDTH = 22;
  localparam int LAT   = 4;
  localparam int CNTW  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  add_2p_sched_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  add_2p_sched #(.WIDTH(WIDTH), .LAT(LAT), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared adder stand-in: sum valid LAT edges after its inputs change.
  logic [WIDTH-1:0] apipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    apipe[0] <= bus.add_x + bus.add_y;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign bus.add_sum = apipe[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    int               id;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] sum;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  exp_ops;
    int  id;
    logic early;
    logic [3:0] expg [5];
    int  expid [5];

    vecs[0] = '{0, 22'd5,       22'd7,       22'd12};
    vecs[1] = '{1, 22'h3FFFFF,  22'h000001,  22'h000000};
    vecs[2] = '{2, 22'h200000,  22'h200000,  22'h000000};
    vecs[3] = '{3, 22'h123456,  22'h0ABCDE,  22'h1CF134};
    vecs[4] = '{1, 22'd100,     22'd200,     22'd300};

    bus.en   = 1'b0;
    bus.req  = 4'b0000;
    bus.x_in = '0;
    bus.y_in = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("reset_gnt",       32'(bus.gnt),       32'h0);
    chk("reset_add_x",     32'(bus.add_x),     32'h0);
    chk("reset_add_y",     32'(bus.add_y),     32'h0);
    chk("reset_res_valid", 32'(bus.res_valid), 32'h0);
    chk("reset_res_sum",   32'(bus.res_sum),   32'h0);
    chk("reset_ops_cnt",   32'(bus.ops_cnt),   32'h0);
    chk("reset_idle",      32'(bus.idle),      32'h1);

    // Single-op vectors: grant next edge, result LAT+1 edges after the grant.
    bus.en  = 1'b1;
    exp_ops = 0;
    for (int v = 0; v < 5; v++) begin
      id = vecs[v].id;
      bus.x_in[id*WIDTH +: WIDTH] = vecs[v].x;
      bus.y_in[id*WIDTH +: WIDTH] = vecs[v].y;
      bus.req = 4'(1 << id);
      tick();
      chk("vec_gnt",   32'(bus.gnt),   32'(1 << id));
      chk("vec_add_x", 32'(bus.add_x), 32'(vecs[v].x));
      chk("vec_add_y", 32'(bus.add_y), 32'(vecs[v].y));
      exp_ops++;
      chk("vec_ops_cnt", 32'(bus.ops_cnt), 32'(exp_ops));
      bus.req = 4'b0000;
      early = 1'b0;
      for (int c = 2; c <= LAT + 1; c++) begin
        tick();
        if (c == 2) chk("vec_gnt_pulse", 32'(bus.gnt), 32'h0);
        if (bus.res_valid) early = 1'b1;
      end
      chk("vec_early_valid", 32'(early), 32'h0);
      tick();
      chk("vec_res_valid", 32'(bus.res_valid), 32'h1);
      chk("vec_res_id",    32'(bus.res_id),    32'(id));
      chk("vec_res_sum",   32'(bus.res_sum),   32'(vecs[v].sum));
      chk("vec_idle",      32'(bus.idle),      32'h1);
      tick();
      chk("vec_res_pulse", 32'(bus.res_valid), 32'h0);
    end

    // Contention from reset: 0,1,2,3,0 back to back, results in issue order.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      bus.x_in[i*WIDTH +: WIDTH] = WIDTH'(i);
      bus.y_in[i*WIDTH +: WIDTH] = WIDTH'(100 * i);
    end
    expg  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    expid = '{0, 1, 2, 3, 0};
    bus.req = 4'b1111;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e <= 5) begin
        chk("rr_gnt", 32'(bus.gnt), 32'(expg[e-1]));
        if (e == 5) bus.req = 4'b0000;
      end else if (e <= 10) begin
        chk("rr_res_valid", 32'(bus.res_valid), 32'h1);
        chk("rr_res_id",    32'(bus.res_id),    32'(expid[e-6]));
        chk("rr_res_sum",   32'(bus.res_sum),   32'(101 * expid[e-6]));
      end else begin
        chk("rr_drained_valid", 32'(bus.res_valid), 32'h0);
        chk("rr_idle",          32'(bus.idle),      32'h1);
        chk("rr_ops_cnt",       32'(bus.ops_cnt),   32'd5);
      end
    end

    // Fairness: after granting 2, pending {3,0} resolves 3 first.
    pulse_reset();
    bus.req = 4'b0100;
    tick();
    chk("fair_gnt2", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b1001;
    tick();
    chk("fair_gnt3", 32'(bus.gnt), 32'b1000);
    tick();
    chk("fair_gnt0", 32'(bus.gnt), 32'b0001);
    bus.req = 4'b0000;
    for (int i = 0; i < 8; i++) tick();

    // en dropped mid-burst: in-flight ops finish, no new grants, then resume.
    pulse_reset();
    bus.en  = 1'b1;
    bus.req = 4'b1111;
    tick();
    chk("en_gnt0", 32'(bus.gnt), 32'b0001);
    tick();
    chk("en_gnt1", 32'(bus.gnt), 32'b0010);
    bus.en = 1'b0;
    for (int e = 3; e <= 9; e++) begin
      tick();
      chk("en_off_gnt", 32'(bus.gnt), 32'h0);
      if (e == 6) begin
        chk("en_res0_valid", 32'(bus.res_valid), 32'h1);
        chk("en_res0_id",    32'(bus.res_id),    32'h0);
        chk("en_res0_sum",   32'(bus.res_sum),   32'h0);
        chk("en_busy",       32'(bus.idle),      32'h0);
      end
      if (e == 7) begin
        chk("en_res1_valid", 32'(bus.res_valid), 32'h1);
        chk("en_res1_id",    32'(bus.res_id),    32'h1);
        chk("en_res1_sum",   32'(bus.res_sum),   32'd101);
        chk("en_idle",       32'(bus.idle),      32'h1);
      end
    end
    bus.en = 1'b1;
    tick();
    chk("en_resume_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b0000;
    for (int i = 0; i < 8; i++) tick();

    // Reset two cycles after three grants discards all in-flight tags.
    pulse_reset();
    bus.req = 4'b1111;
    tick();
    tick();
    tick();
    chk("rst_third_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b0000;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_gnt",       32'(bus.gnt),       32'h0);
    chk("rst_add_x",     32'(bus.add_x),     32'h0);
    chk("rst_add_y",     32'(bus.add_y),     32'h0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_res_id",    32'(bus.res_id),    32'h0);
    chk("rst_res_sum",   32'(bus.res_sum),   32'h0);
    chk("rst_ops_cnt",   32'(bus.ops_cnt),   32'h0);
    chk("rst_idle",      32'(bus.idle),      32'h1);
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.res_valid) early = 1'b1;
    end
    chk("rst_no_stale_valid", 32'(early), 32'h0);
    bus.req = 4'b1111;
    tick();
    chk("rst_next_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = 4'b0000;
    for (int i = 0; i < 8; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
